te_branch_map: RTL and testbench

//  Downstream of the trace input register stage. Consumes the registered retirement stream, finds

---
 rtl/te_branch_map.sv | 170 +++++++++++++++++
 tb/tb_te_branch_map.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/te_branch_map.sv
// te_branch_map
// Collects conditional-branch outcomes from the registered retirement stream
// and packs them into branch maps (bit = 1 means not taken). Each finished map
// is handed to the packet encoder over a valid/ready handshake. Traps and
// explicit flushes close the current map early.
// Optional feature: define TE_COMPRESSED_EN to also recognise c.beqz/c.bnez.
module te_branch_map #(
    parameter int MAP_LEN = 31,
    localparam int CNT_W = $clog2(MAP_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ivalid_i,
    input  logic               iexception_i,
    input  logic               interrupt_i,
    input  logic [31:0]        iaddr_i,
    input  logic [31:0]        instr_i,
    input  logic               flush_i,
    output logic               map_valid_o,
    input  logic               map_ready_i,
    output logic [MAP_LEN-1:0] map_bits_o,
    output logic [CNT_W-1:0]   map_cnt_o,
    output logic               map_ovf_o
);

    localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(MAP_LEN);

    logic               pending_q;
    logic [31:0]        pend_next_q;
    logic [MAP_LEN-1:0] acc_q, acc_n, acc_app;
    logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_app;
    logic               ovf_q, ovf_n;
    logic               close_pend_q, close_n;

    logic               is_trap;
    logic               is_branch32;
    logic               is_branch16;
    logic               is_branch;
    logic [31:0]        branch_step;
    logic               resolve;
    logic               outcome;
    logic               close_now;
    logic               out_free;
    logic               xfer;
    logic [MAP_LEN-1:0] xfer_bits;
    logic [CNT_W-1:0]   xfer_cnt;

    assign is_trap     = ivalid_i & (iexception_i | interrupt_i);
    assign is_branch32 = ivalid_i & ~iexception_i & ~interrupt_i
                         & (instr_i[6:0] == OPC_BRANCH);

`ifdef TE_COMPRESSED_EN
    logic unused_instr;
    assign unused_instr = ^{instr_i[31:16], instr_i[12:7]};
    // c.beqz / c.bnez: quadrant 01 with funct3 110 or 111
    assign is_branch16 = ivalid_i & ~iexception_i & ~interrupt_i
                         & (instr_i[1:0] == 2'b01) & (instr_i[15:14] == 2'b11);
`else
    logic unused_instr;
    assign unused_instr = ^instr_i[31:7];
    assign is_branch16  = 1'b0;
`endif

    assign is_branch   = is_branch32 | is_branch16;
    assign branch_step = is_branch16 ? 32'd2 : 32'd4;
    assign resolve     = ivalid_i & pending_q;
    assign outcome     = (iaddr_i == pend_next_q);
    assign close_now   = flush_i | is_trap;
    assign out_free    = ~map_valid_o | map_ready_i;

    // Track the one outstanding branch whose fall-through address decides its outcome
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= 1'b0;
            pend_next_q <= '0;
        end else if (ivalid_i) begin
            pending_q <= is_branch;
            if (is_branch) begin
                pend_next_q <= iaddr_i + branch_step;
            end
        end
    end

    // Append outcomes, decide when the accumulator moves to the output, handle drops
    always_comb begin
        acc_n     = acc_q;
        cnt_n     = cnt_q;
        ovf_n     = ovf_q;
        close_n   = close_pend_q;
        xfer      = 1'b0;
        xfer_bits = acc_q;
        xfer_cnt  = cnt_q;
        acc_app   = acc_q;
        cnt_app   = cnt_q;
        if (cnt_q == CNT_FULL) begin
            if (out_free) begin
                xfer    = 1'b1;
                acc_n   = '0;
                cnt_n   = '0;
                ovf_n   = 1'b0;
                close_n = 1'b0;
                if (resolve) begin
                    acc_n[0] = outcome;
                    cnt_n    = CNT_W'(1);
                    close_n  = close_now;
                end
            end else begin
                if (resolve) begin
                    ovf_n = 1'b1;
                end
                close_n = close_pend_q | close_now;
            end
        end else begin
            if (resolve) begin
                acc_app[cnt_q] = outcome;
            end
            cnt_app = cnt_q + CNT_W'(resolve);
            if (((cnt_app == CNT_FULL) || close_now || close_pend_q)
                && (cnt_app != '0) && out_free) begin
                xfer      = 1'b1;
                xfer_bits = acc_app;
                xfer_cnt  = cnt_app;
                acc_n     = '0;
                cnt_n     = '0;
                ovf_n     = 1'b0;
                close_n   = 1'b0;
            end else begin
                acc_n = acc_app;
                cnt_n = cnt_app;
                if (cnt_app != '0) begin
                    close_n = close_pend_q | close_now;
                end
            end
        end
    end

    // Accumulator state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            close_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_n;
            cnt_q        <= cnt_n;
            ovf_q        <= ovf_n;
            close_pend_q <= close_n;
        end
    end

    // Output map register, held stable until the consumer accepts it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_valid_o <= 1'b0;
            map_bits_o  <= '0;
            map_cnt_o   <= '0;
            map_ovf_o   <= 1'b0;
        end else if (xfer) begin
            map_valid_o <= 1'b1;
            map_bits_o  <= xfer_bits;
            map_cnt_o   <= xfer_cnt;
            map_ovf_o   <= ovf_q;
        end else if (map_ready_i) begin
            map_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_te_branch_map.sv
// tb_te_branch_map
// Directed testbench for te_branch_map with hand-computed expectations.
// Define TE_COMPRESSED_EN for both files to exercise the compressed decoder.
module tb_te_branch_map;

    localparam int MAP_LEN = 31;
    localparam logic [31:0] BEQ    = 32'h0000_0063;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] C_BEQZ = 32'h0000_C001;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ivalid_i;
    logic        iexception_i;
    logic        interrupt_i;
    logic [31:0] iaddr_i;
    logic [31:0] instr_i;
    logic        flush_i;
    logic        map_valid_o;
    logic        map_ready_i;
    logic [30:0] map_bits_o;
    logic [4:0]  map_cnt_o;
    logic        map_ovf_o;

    int checks = 0;
    int errors = 0;

    te_branch_map #(.MAP_LEN(MAP_LEN)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ivalid_i     (ivalid_i),
        .iexception_i (iexception_i),
        .interrupt_i  (interrupt_i),
        .iaddr_i      (iaddr_i),
        .instr_i      (instr_i),
        .flush_i      (flush_i),
        .map_valid_o  (map_valid_o),
        .map_ready_i  (map_ready_i),
        .map_bits_o   (map_bits_o),
        .map_cnt_o    (map_cnt_o),
        .map_ovf_o    (map_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock with the given inputs; returns 1 time unit after the edge with inputs idle
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] ins,
                         input logic exc, input logic intr, input logic fl);
        ivalid_i     = v;
        iaddr_i      = a;
        instr_i      = ins;
        iexception_i = exc;
        interrupt_i  = intr;
        flush_i      = fl;
        @(posedge clk_i);
        #1;
        ivalid_i     = 1'b0;
        iexception_i = 1'b0;
        interrupt_i  = 1'b0;
        flush_i      = 1'b0;
    endtask

    function automatic logic not_taken(input int mode, input int k);
        case (mode)
            1:       return (k < 31) ? 1'b1 : (((k - 31) % 3) == 0);
            2:       return (k == 1);
            default: return (k % 2) == 0;
        endcase
    endfunction

    // n chained branches then a plain instruction that resolves the last one
    task automatic run_chain(input int n, input logic [31:0] start, input int mode);
        logic [31:0] a;
        a = start;
        for (int k = 0; k < n; k++) begin
            drive(1'b1, a, BEQ, 1'b0, 1'b0, 1'b0);
            a = not_taken(mode, k) ? a + 32'd4 : a + 32'h40;
        end
        drive(1'b1, a, NOP, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; map_ready_i = 1'b0;
        ivalid_i = 1'b0; iexception_i = 1'b0; interrupt_i = 1'b0;
        flush_i = 1'b0; iaddr_i = '0; instr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", map_valid_o); end
        checks++;
        if (map_bits_o !== 31'd0) begin errors++; $display("[TB] FAIL reset_bits got %h exp 0", map_bits_o); end
        checks++;
        if (map_cnt_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", map_cnt_o); end
        checks++;
        if (map_ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %0b exp 0", map_ovf_o); end
        rst_ni = 1'b1;
        map_ready_i = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single;
        drive(1'b1, 32'h100, BEQ, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h104, NOP, 1'b0, 1'b0, 1'b0);
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_novalid got %0b exp 0", map_valid_o); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (map_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0b exp 1", map_valid_o); end
        checks++;
        if (map_bits_o !== 31'h1) begin errors++; $display("[TB] FAIL single_bits got %h exp 1", map_bits_o); end
        checks++;
        if (map_cnt_o !== 5'd1) begin errors++; $display("[TB] FAIL single_cnt got %0d exp 1", map_cnt_o); end
        checks++;
        if (map_ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL single_ovf got %0b exp 0", map_ovf_o); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_consumed got %0b exp 0", map_valid_o); end
    endtask

    task automatic test_full_map;
        logic [31:0] a;
        a = 32'h1000;
        for (int k = 0; k < 31; k++) begin
            drive(1'b1, a, BEQ, 1'b0, 1'b0, 1'b0);
            a = not_taken(0, k) ? a + 32'd4 : a + 32'h40;
        end
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL full_early got %0b exp 0", map_valid_o); end
        drive(1'b1, a, NOP, 1'b0, 1'b0, 1'b0);
        checks++;
        if (map_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL full_valid got %0b exp 1", map_valid_o); end
        checks++;
        if (map_bits_o !== 31'h5555_5555) begin errors++; $display("[TB] FAIL full_bits got %h exp 55555555", map_bits_o); end
        checks++;
        if (map_cnt_o !== 5'd31) begin errors++; $display("[TB] FAIL full_cnt got %0d exp 31", map_cnt_o); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_partial_flush;
        run_chain(3, 32'h2000, 2);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (map_cnt_o !== 5'd3 || map_valid_o !== 1'b1) begin
            errors++; $display("[TB] FAIL partial_cnt got cnt=%0d valid=%0b exp cnt=3 valid=1", map_cnt_o, map_valid_o);
        end
        checks++;
        if (map_bits_o !== 31'h2) begin errors++; $display("[TB] FAIL partial_bits got %h exp 2", map_bits_o); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL empty_flush got %0b exp 0", map_valid_o); end
    endtask

    task automatic test_back_to_back;
        map_ready_i = 1'b0;
        run_chain(63, 32'h3000, 1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (map_valid_o !== 1'b1 || map_bits_o !== 31'h7FFF_FFFF) begin
            errors++; $display("[TB] FAIL held_map1 got valid=%0b bits=%h exp 1/7fffffff", map_valid_o, map_bits_o);
        end
        checks++;
        if (map_cnt_o !== 5'd31 || map_ovf_o !== 1'b0) begin
            errors++; $display("[TB] FAIL held_map1_cnt got cnt=%0d ovf=%0b exp 31/0", map_cnt_o, map_ovf_o);
        end
        map_ready_i = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (map_valid_o !== 1'b1 || map_bits_o !== 31'h4924_9249) begin
            errors++; $display("[TB] FAIL map2_bits got valid=%0b bits=%h exp 1/49249249", map_valid_o, map_bits_o);
        end
        checks++;
        if (map_cnt_o !== 5'd31 || map_ovf_o !== 1'b1) begin
            errors++; $display("[TB] FAIL map2_ovf got cnt=%0d ovf=%0b exp 31/1", map_cnt_o, map_ovf_o);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL map2_consumed got %0b exp 0", map_valid_o); end
    endtask

    task automatic test_trap;
        drive(1'b1, 32'h100, BEQ, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h800, BEQ, 1'b1, 1'b0, 1'b0);
        checks++;
        if (map_valid_o !== 1'b1 || map_bits_o !== 31'h0) begin
            errors++; $display("[TB] FAIL trap_bits got valid=%0b bits=%h exp 1/0", map_valid_o, map_bits_o);
        end
        checks++;
        if (map_cnt_o !== 5'd1) begin errors++; $display("[TB] FAIL trap_cnt got %0d exp 1", map_cnt_o); end
        drive(1'b1, 32'h804, NOP, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL trap_not_branch got %0b exp 0", map_valid_o); end
    endtask

    task automatic test_compressed;
        drive(1'b1, 32'h100, C_BEQZ, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h102, NOP, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
`ifdef TE_COMPRESSED_EN
        checks++;
        if (map_valid_o !== 1'b1 || map_bits_o !== 31'h1 || map_cnt_o !== 5'd1) begin
            errors++; $display("[TB] FAIL cbranch got valid=%0b bits=%h cnt=%0d exp 1/1/1", map_valid_o, map_bits_o, map_cnt_o);
        end
`else
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL cbranch_off got %0b exp 0", map_valid_o); end
`endif
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        run_chain(2, 32'h4000, 0);
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (map_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid got %0b exp 0", map_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_map();
        test_partial_flush();
        test_back_to_back();
        test_trap();
        test_compressed();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
